// File: rtl/spi_reg_responder_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and constants for the SPI register responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CMD    = 2'd1,
        S_DATA   = 2'd2,
        S_IGNORE = 2'd3
    } spi_state_t;

    localparam int         SPI_RW_BIT     = 7;
    localparam int         SPI_CMD_ADDR_W = 7;
    localparam logic [7:0] SPI_ID_BYTE    = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/spi_reg_responder_if.sv
// ============================================================================
// Module   : spi_reg_responder_if
// Purpose  : SPI pins plus host register port of the SPI register responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spi_reg_responder_if #(
    parameter int ADDR_W = 4
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_rdata;
    logic              hw_we;
    logic [ADDR_W-1:0] hw_addr;
    logic [7:0]        hw_wdata;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              xfer_err;

    modport slave (
        input  sclk, cs, mosi, host_addr, hw_we, hw_addr, hw_wdata,
        output miso, host_rdata, wr_valid, wr_addr, wr_data, busy, xfer_err
    );

    modport master (
        output sclk, cs, mosi, host_addr, hw_we, hw_addr, hw_wdata,
        input  miso, host_rdata, wr_valid, wr_addr, wr_data, busy, xfer_err
    );
endinterface

`default_nettype wire

// File: rtl/spi_resp_regfile.sv
// ============================================================================
// Module   : spi_resp_regfile
// Purpose  : Byte register file, SPI/host write ports (SPI wins), two reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_resp_regfile #(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_spi_we,
    input  wire logic [ADDR_W-1:0] i_spi_addr,
    input  wire logic [7:0]        i_spi_wdata,
    input  wire logic              i_host_we,
    input  wire logic [ADDR_W-1:0] i_host_addr,
    input  wire logic [7:0]        i_host_wdata,
    input  wire logic [ADDR_W-1:0] i_ra_addr,
    output logic [7:0]             o_ra_data,
    input  wire logic [ADDR_W-1:0] i_rb_addr,
    output logic [7:0]             o_rb_data
);
    localparam int c_DEPTH = 1 << ADDR_W;

    logic [7:0] r_mem [c_DEPTH];

    // SPI write is issued last so it overrides a same-index host write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else begin
            if (i_host_we) r_mem[i_host_addr] <= i_host_wdata;
            if (i_spi_we)  r_mem[i_spi_addr]  <= i_spi_wdata;
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule

`default_nettype wire

// File: rtl/spi_reg_responder.sv
// ============================================================================
// Module   : spi_reg_responder
// Purpose  : SPI mode-0 register responder; define SPI_RESP_AUTOINC_EN for bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] ID_BYTE   = SPI_ID_BYTE
) (
    input wire logic           clk,
    input wire logic           reset,
    spi_reg_responder_if.slave bus
);
    spi_state_t                r_state, w_state_next;
    logic                      r_sclk_prev, r_cs_prev, r_armed;
    logic [2:0]                r_bit_idx;
    logic [6:0]                r_rx;
    logic [7:0]                r_tx;
    logic                      r_miso, r_rw, r_busy, r_wr_valid, r_xfer_err;
    logic [SPI_CMD_ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [7:0]                r_wr_data;

    logic       w_rise, w_fall, w_cs_fall, w_cs_rise, w_start;
    logic       w_byte_done, w_oor, w_spi_we;
    logic [7:0] w_byte, w_rd_data, w_load;

    assign w_rise      = !r_sclk_prev && bus.sclk;
    assign w_fall      = r_sclk_prev && !bus.sclk;
    assign w_cs_fall   = r_cs_prev && !bus.cs;
    assign w_cs_rise   = !r_cs_prev && bus.cs;
    // r_armed blocks a frame start until cs has been seen high since reset.
    assign w_start     = (r_state == S_IDLE) && w_cs_fall && r_armed;
    assign w_byte      = {r_rx, bus.mosi};
    assign w_byte_done = w_rise && (r_bit_idx == 3'd0);
    assign w_oor       = |r_addr[SPI_CMD_ADDR_W-1:ADDR_W];
    assign w_spi_we    = (r_state == S_DATA) && w_byte_done && !r_rw && !w_oor;
    assign w_load      = (r_rw && !w_oor) ? w_rd_data : 8'h00;

    spi_resp_regfile #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .i_spi_we     (w_spi_we),
        .i_spi_addr   (r_addr[ADDR_W-1:0]),
        .i_spi_wdata  (w_byte),
        .i_host_we    (bus.hw_we),
        .i_host_addr  (bus.hw_addr),
        .i_host_wdata (bus.hw_wdata),
        .i_ra_addr    (bus.host_addr),
        .o_ra_data    (bus.host_rdata),
        .i_rb_addr    (r_addr[ADDR_W-1:0]),
        .o_rb_data    (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_CMD;
            S_CMD:    if (w_byte_done) w_state_next = S_DATA;
            S_DATA: begin
`ifdef SPI_RESP_AUTOINC_EN
                w_state_next = S_DATA;
`else
                if (w_byte_done) w_state_next = S_IGNORE;
`endif
            end
            S_IGNORE: w_state_next = S_IGNORE;
            default:  w_state_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && w_cs_rise) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_armed     <= 1'b0;
            r_bit_idx   <= 3'd7;
            r_rx        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_xfer_err  <= 1'b0;
        end else begin
            r_sclk_prev <= bus.sclk;
            r_cs_prev   <= bus.cs;
            r_wr_valid  <= 1'b0;
            r_xfer_err  <= 1'b0;
            r_busy      <= (w_state_next != S_IDLE);
            if (bus.cs) r_armed <= 1'b1;

            if (r_state != S_IDLE && w_cs_rise) begin
                r_miso     <= 1'b0;
                r_bit_idx  <= 3'd7;
                r_xfer_err <= (r_state == S_CMD || r_state == S_DATA) && (r_bit_idx != 3'd7);
            end else if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_miso    <= ID_BYTE[7];
                    r_tx      <= {ID_BYTE[6:0], 1'b0};
                    r_bit_idx <= 3'd7;
                end
            end else begin
                if (w_rise) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_idx <= r_bit_idx - 3'd1;
                    if (w_byte_done && r_state == S_CMD) begin
                        r_rw   <= w_byte[SPI_RW_BIT];
                        r_addr <= w_byte[SPI_CMD_ADDR_W-1:0];
                    end
                    if (w_byte_done && r_state == S_DATA) begin
                        if (w_spi_we) begin
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= r_addr[ADDR_W-1:0];
                            r_wr_data  <= w_byte;
                        end
`ifdef SPI_RESP_AUTOINC_EN
                        r_addr <= {r_addr[SPI_CMD_ADDR_W-1:ADDR_W],
                                   r_addr[ADDR_W-1:0] + ADDR_W'(1)};
`else
                        r_addr <= r_addr;
`endif
                    end
                end
                // The first fall after a data-phase byte boundary loads the next read byte.
                if (w_fall) begin
                    if (r_state == S_IGNORE) begin
                        r_miso <= 1'b0;
                        r_tx   <= '0;
                    end else if (r_state == S_DATA && r_bit_idx == 3'd7) begin
                        r_miso <= w_load[7];
                        r_tx   <= {w_load[6:0], 1'b0};
                    end else begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.miso     = r_miso;
    assign bus.busy     = r_busy;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.xfer_err = r_xfer_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
// ============================================================================
// Module   : tb_spi_reg_responder
// Purpose  : Directed vector bench for spi_reg_responder (with or without SPI_RESP_AUTOINC_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_reg_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_reg_responder_if #(.ADDR_W(4)) bus ();

    spi_reg_responder #(
        .ADDR_W    (4),
        .RESET_VAL (8'h00),
        .ID_BYTE   (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [3:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wr_cnt++;
            last_wr_addr = bus.wr_addr;
            last_wr_data = bus.wr_data;
        end
        if (bus.xfer_err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.mosi = tx[i];
            @(posedge clk); @(negedge clk);
            rx[i] = bus.miso;
            @(posedge clk); #1;
            bus.sclk = 1'b1;
            if (collide && i == 0) bus.hw_we = 1'b1;
            @(posedge clk); #1;
            bus.hw_we = 1'b0;
            @(posedge clk); #1;
            bus.sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        bus.hw_addr = a; bus.hw_wdata = d; bus.hw_we = 1'b1;
        @(posedge clk); #1;
        bus.hw_we = 1'b0;
    endtask

    task automatic reg_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        bus.host_addr = a;
        @(negedge clk);
        chk(name, bus.host_rdata, exp);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_cmd_miso;
        logic [7:0] exp_data_miso;
        int         exp_wr;
        logic [3:0] chk_idx;
        logic [7:0] exp_reg;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        logic [7:0] r0, r1, r2;
        int w0, e0;

        vecs[0] = '{8'h03, 8'h5C, 8'hA5, 8'h00, 1, 4'd3,  8'h5C};
        vecs[1] = '{8'h83, 8'h00, 8'hA5, 8'h5C, 0, 4'd3,  8'h5C};
        vecs[2] = '{8'h0A, 8'h3C, 8'hA5, 8'h00, 1, 4'd10, 8'h3C};
        vecs[3] = '{8'h8A, 8'h00, 8'hA5, 8'h3C, 0, 4'd10, 8'h3C};
        vecs[4] = '{8'hF0, 8'h00, 8'hA5, 8'h00, 0, 4'd0,  8'h00};
        vecs[5] = '{8'h70, 8'hFF, 8'hA5, 8'h00, 0, 4'd0,  8'h00};
        vecs[6] = '{8'h85, 8'h00, 8'hA5, 8'h00, 0, 4'd5,  8'h00};
        vecs[7] = '{8'h0F, 8'h81, 8'hA5, 8'h00, 1, 4'd15, 8'h81};
        vecs[8] = '{8'h8F, 8'h00, 8'hA5, 8'h81, 0, 4'd15, 8'h81};

        bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
        bus.host_addr = '0; bus.hw_we = 1'b0; bus.hw_addr = '0; bus.hw_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_miso",     bus.miso,       0);
        chk("rst_busy",     bus.busy,       0);
        chk("rst_wr_valid", bus.wr_valid,   0);
        chk("rst_wr_addr",  bus.wr_addr,    0);
        chk("rst_wr_data",  bus.wr_data,    0);
        chk("rst_xfer_err", bus.xfer_err,   0);
        chk("rst_reg",      bus.host_rdata, 8'h00);
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            w0 = wr_cnt;
            bus.cs = 1'b0;
            spi_byte(vecs[v].cmd, 8, 1'b0, r0);
            chk($sformatf("v%0d_busy", v), bus.busy, 1);
            spi_byte(vecs[v].data, 8, 1'b0, r1);
            end_frame();
            chk($sformatf("v%0d_cmd_miso", v),  r0, vecs[v].exp_cmd_miso);
            chk($sformatf("v%0d_data_miso", v), r1, vecs[v].exp_data_miso);
            chk($sformatf("v%0d_wr_cnt", v),    wr_cnt - w0, vecs[v].exp_wr);
            if (vecs[v].exp_wr != 0) begin
                chk($sformatf("v%0d_wr_addr", v), last_wr_addr, vecs[v].chk_idx);
                chk($sformatf("v%0d_wr_data", v), last_wr_data, vecs[v].exp_reg);
            end
            reg_chk($sformatf("v%0d_reg", v), vecs[v].chk_idx, vecs[v].exp_reg);
            chk($sformatf("v%0d_idle_busy", v), bus.busy, 0);
            chk($sformatf("v%0d_idle_miso", v), bus.miso, 0);
            @(posedge clk); #1;
        end

        // host preload then SPI read; host writes never pulse wr_valid
        w0 = wr_cnt;
        host_write(4'd6, 8'hC3);
        reg_chk("host_wr_reg6", 4'd6, 8'hC3);
        @(posedge clk); #1;
        bus.cs = 1'b0;
        spi_byte(8'h86, 8, 1'b0, r0);
        spi_byte(8'h00, 8, 1'b0, r1);
        end_frame();
        chk("host_rd_miso", r1, 8'hC3);
        chk("host_no_wr_valid", wr_cnt - w0, 0);

        // burst
        host_write(4'd0, 8'h99);
        w0 = wr_cnt;
        bus.cs = 1'b0;
        spi_byte(8'h0F, 8, 1'b0, r0);
        spi_byte(8'h11, 8, 1'b0, r1);
        spi_byte(8'h22, 8, 1'b0, r2);
        end_frame();
        reg_chk("burst_reg15", 4'd15, 8'h11);
`ifdef SPI_RESP_AUTOINC_EN
        reg_chk("burst_reg0", 4'd0, 8'h22);
        chk("burst_wr_cnt", wr_cnt - w0, 2);
`else
        reg_chk("burst_reg0", 4'd0, 8'h99);
        chk("burst_wr_cnt", wr_cnt - w0, 1);
        chk("burst_ignore_miso", r2, 8'h00);
`endif
        @(posedge clk); #1;

        // aborted data byte
        host_write(4'd2, 8'h77);
        w0 = wr_cnt; e0 = err_cnt;
        bus.cs = 1'b0;
        spi_byte(8'h02, 8, 1'b0, r0);
        spi_byte(8'hAA, 4, 1'b0, r1);
        end_frame();
        chk("abort_xfer_err", err_cnt - e0, 1);
        chk("abort_no_wr", wr_cnt - w0, 0);
        reg_chk("abort_reg2", 4'd2, 8'h77);
        @(posedge clk); #1;

        // SPI and host writing the same index in the same cycle
        w0 = wr_cnt;
        bus.cs = 1'b0;
        spi_byte(8'h04, 8, 1'b0, r0);
        bus.hw_addr = 4'd4; bus.hw_wdata = 8'hEE;
        spi_byte(8'h6B, 8, 1'b1, r1);
        end_frame();
        reg_chk("collide_reg4", 4'd4, 8'h6B);
        chk("collide_wr_cnt", wr_cnt - w0, 1);
        chk("collide_wr_data", last_wr_data, 8'h6B);
        @(posedge clk); #1;

        // async reset mid-command with cs held low
        w0 = wr_cnt; e0 = err_cnt;
        bus.cs = 1'b0;
        spi_byte(8'h83, 4, 1'b0, r0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_miso", bus.miso, 0);
        bus.host_addr = 4'd3;
        #1;
        chk("arst_reg3", bus.host_rdata, 8'h00);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        spi_byte(8'h03, 8, 1'b0, r0);
        spi_byte(8'hFF, 8, 1'b0, r1);
        @(negedge clk);
        chk("arst_no_start_busy", bus.busy, 0);
        chk("arst_no_start_miso", r0, 8'h00);
        chk("arst_no_wr", wr_cnt - w0, 0);
        @(posedge clk); #1;
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.cs = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("arst_restart_busy", bus.busy, 1);
        @(posedge clk); #1;
        spi_byte(8'h83, 8, 1'b0, r0);
        spi_byte(8'h00, 8, 1'b0, r1);
        end_frame();
        chk("arst_restart_cmd", r0, 8'hA5);
        chk("arst_restart_data", r1, 8'h00);
        chk("arst_no_err", err_cnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
